// File: rtl/ts_merge_sched.sv
// ts_merge_sched: paced round-robin packet scheduler for the shared TS merge output port.
// Optional null-packet fill while no channel requests: define TS_SCHED_NULL_EN.
module ts_merge_sched #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 4,
  parameter int PKT_LEN = 188,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic              byte_en,
  output logic              pkt_sof,
  output logic              pkt_eof,
  output logic              busy,
  output logic              null_sel
);
  // state | meaning
  // IDLE  | no packet in flight; arbitrate among requests
  // SEND  | granted (or null) packet streaming, one byte per tick
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [NUM_CH-1:0] grant_nxt;
  logic              null_sel_nxt;
  logic              found;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  cand;
  int                idx;

  // Compare against the live div_val so a reprogrammed ratio applies at once.
  assign tick = (div_cnt >= div_val);

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Scan starts one past the last winner, so a lone requester wraps to itself.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = rr_ptr;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx  = (int'(rr_ptr) + i) % NUM_CH;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign busy    = (state == SEND);
  assign byte_en = busy & tick;
  assign pkt_sof = byte_en & (byte_cnt == '0);
  assign pkt_eof = byte_en & (byte_cnt == LAST_BYTE);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    byte_cnt_nxt = byte_cnt;
    null_sel_nxt = null_sel;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = SEND;
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          rr_ptr_nxt     = win;
          byte_cnt_nxt   = '0;
          null_sel_nxt   = 1'b0;
        end
`ifdef TS_SCHED_NULL_EN
        else if (tick) begin
          state_nxt    = SEND;
          grant_nxt    = '0;
          byte_cnt_nxt = '0;
          null_sel_nxt = 1'b1;
        end
`endif
      end
      SEND: begin
        if (pkt_eof) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          null_sel_nxt = 1'b0;
        end else if (byte_en) begin
          byte_cnt_nxt = byte_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= PTR_W'(NUM_CH - 1);
      byte_cnt <= '0;
      null_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      null_sel <= null_sel_nxt;
    end
  end

endmodule

// File: tb/tb_ts_merge_sched.sv
// Self-checking bench for ts_merge_sched: table of packet grants plus reset,
// divider-change and idle/null-packet sequences.
module tb_ts_merge_sched;
  localparam int PKT_LEN = 188;

  logic       clk;
  logic       rst;
  logic [3:0] div_val;
  logic [3:0] req;
  logic [3:0] grant;
  logic       byte_en, pkt_sof, pkt_eof, busy, null_sel;

  int total = 0;
  int bad   = 0;

  ts_merge_sched #(.NUM_CH(4), .DIV_W(4), .PKT_LEN(PKT_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .div_val(div_val), .req(req), .grant(grant),
    .byte_en(byte_en), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof), .busy(busy),
    .null_sel(null_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] div;
    logic [3:0] req;
    logic [3:0] exp_grant;
    int         drop_at;    // byte number after which req is replaced (0 = never)
    logic [3:0] req_after;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered at the negedge right after the grant edge; leaves at the negedge of
  // the idle cycle that follows eof.
  task automatic run_pkt(input logic [3:0] exp_grant, input int exp_gap,
                         input int drop_at, input logic [3:0] req_after,
                         input logic exp_null);
    int n, cyc, last, sof_bad, eof_bad, gap_bad, hold_bad;
    n = 0; cyc = 0; last = -1;
    sof_bad = 0; eof_bad = 0; gap_bad = 0; hold_bad = 0;
    check("grant_start", int'(grant), int'(exp_grant));
    check("busy_start", int'(busy), 1);
    check("null_start", int'(null_sel), int'(exp_null));
    while (n < PKT_LEN && cyc < 5000) begin
      if (grant !== exp_grant || null_sel !== exp_null || busy !== 1'b1) hold_bad++;
      if (byte_en) begin
        if (pkt_sof !== (n == 0)) sof_bad++;
        if (pkt_eof !== (n == PKT_LEN - 1)) eof_bad++;
        if (last >= 0 && (cyc - last) != exp_gap) gap_bad++;
        last = cyc;
        n++;
        if (n == drop_at) req = req_after;
      end else if (pkt_sof || pkt_eof) begin
        sof_bad++;
      end
      if (n < PKT_LEN) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("byte_count", n, PKT_LEN);
    check("sof_errors", sof_bad, 0);
    check("eof_errors", eof_bad, 0);
    check("gap_errors", gap_bad, 0);
    check("hold_errors", hold_bad, 0);
    @(negedge clk);
    check("idle_grant", int'(grant), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_null", int'(null_sel), 0);
  endtask

  initial begin
    int n, cyc;
    vecs[0] = '{div: 4'd0, req: 4'b1011, exp_grant: 4'b0001, drop_at: 0,  req_after: 4'b0000};
    vecs[1] = '{div: 4'd0, req: 4'b1011, exp_grant: 4'b0010, drop_at: 0,  req_after: 4'b0000};
    vecs[2] = '{div: 4'd0, req: 4'b1011, exp_grant: 4'b1000, drop_at: 0,  req_after: 4'b0000};
    vecs[3] = '{div: 4'd0, req: 4'b1011, exp_grant: 4'b0001, drop_at: 0,  req_after: 4'b0000};
    vecs[4] = '{div: 4'd2, req: 4'b0100, exp_grant: 4'b0100, drop_at: 0,  req_after: 4'b0000};
    vecs[5] = '{div: 4'd1, req: 4'b0010, exp_grant: 4'b0010, drop_at: 50, req_after: 4'b0000};
    vecs[6] = '{div: 4'd3, req: 4'b0010, exp_grant: 4'b0010, drop_at: 0,  req_after: 4'b0000};
    vecs[7] = '{div: 4'd0, req: 4'b1100, exp_grant: 4'b0100, drop_at: 10, req_after: 4'b1111};
    vecs[8] = '{div: 4'd0, req: 4'b1100, exp_grant: 4'b1000, drop_at: 0,  req_after: 4'b0000};
    vecs[9] = '{div: 4'd0, req: 4'b1111, exp_grant: 4'b0001, drop_at: 0,  req_after: 4'b0000};

    // reset with all channels requesting
    rst = 1'b1; req = 4'b1111; div_val = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_outputs", int'({grant, byte_en, pkt_sof, pkt_eof, busy, null_sel}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_grant", int'(grant), 1);
    check("rst_first_busy", int'(busy), 1);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req     = vecs[i].req;
      div_val = vecs[i].div;
      @(negedge clk);
      run_pkt(vecs[i].exp_grant, int'(vecs[i].div) + 1, vecs[i].drop_at,
              vecs[i].req_after, 1'b0);
    end

    // reset in the middle of a packet
    req = 4'b0001; div_val = 4'd0;
    @(negedge clk);
    n = 0; cyc = 0;
    while (n < 100 && cyc < 500) begin
      if (byte_en) n++;
      if (n < 100) begin @(negedge clk); cyc++; end
    end
    check("pre_rst_bytes", n, 100);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", int'({grant, byte_en, pkt_sof, pkt_eof, busy, null_sel}), 0);

    // divider ratio reprogrammed while div_cnt is 5
    do_reset();
    req = 4'b0001; div_val = 4'd7;
    @(negedge clk);
    cyc = 0;
    while (!byte_en && cyc < 20) begin @(negedge clk); cyc++; end
    check("div7_first_tick", int'(byte_en), 1);
    repeat (6) @(negedge clk);
    check("div7_cnt5_no_tick", int'(byte_en), 0);
    div_val = 4'd1;
    #1;
    check("div1_immediate", int'(byte_en), 1);
    n = 2;
    @(negedge clk); check("div1_gap_a", int'(byte_en), 0);
    @(negedge clk); check("div1_tick_a", int'(byte_en), 1); n += int'(byte_en);
    @(negedge clk); check("div1_gap_b", int'(byte_en), 0);
    @(negedge clk); check("div1_tick_b", int'(byte_en), 1); n += int'(byte_en);
    cyc = 0;
    while (n < PKT_LEN && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (byte_en) begin
        n++;
        if (n == PKT_LEN) check("div_eof_last", int'(pkt_eof), 1);
      end
    end
    check("div_total_bytes", n, PKT_LEN);
    @(negedge clk);
    check("div_idle_grant", int'(grant), 0);

    // idle behaviour with no requests
    do_reset();
    div_val = 4'd0;
`ifdef TS_SCHED_NULL_EN
    @(negedge clk);
    run_pkt(4'b0000, 1, 30, 4'b0001, 1'b1);
    @(negedge clk);
    check("after_null_grant", int'(grant), 1);
`else
    repeat (5) @(negedge clk);
    check("noreq_busy", int'(busy), 0);
    check("noreq_byte_en", int'(byte_en), 0);
    check("noreq_null", int'(null_sel), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
